// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered WIDTH-bit arithmetic/logic unit
//
// Eight operations are selected by a 3-bit opcode. Each accepted input
// produces a result and four flags one clock later. This is the leaf
// datapath block that the sequencing logic uses for register-to-register
// operations.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      a/b/s are sampled on a clk edge when 1
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (ignored by NOT/SHL/SHR)
//   s          in   3      opcode select
//   y          out  WIDTH  registered result
//   c          out  1      carry / borrow / shifted-out bit
//   z          out  1      result is zero
//   n          out  1      result MSB
//   v          out  1      signed overflow (ADD/SUB only)
//   out_valid  out  1      high for one cycle after each accepted input
// ---------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             out_valid
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    localparam int MSB = WIDTH - 1;

    op_e              op;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             ovf_next;

    assign op = op_e'(s);

    // One extra bit on each side: bit WIDTH of the sum is the carry out,
    // bit WIDTH of the difference is set exactly when a < b (borrow).
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        ovf_next    = 1'b0;
        case (op)
            OP_ADD: begin
                result_next = sum_ext[WIDTH-1:0];
                carry_next  = sum_ext[WIDTH];
                // Same-sign operands whose sum flips sign overflowed.
                ovf_next    = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result_next = diff_ext[WIDTH-1:0];
                carry_next  = diff_ext[WIDTH];
                // Opposite-sign operands whose difference leaves a's sign overflowed.
                ovf_next    = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
            end
            OP_AND: result_next = a & b;
            OP_OR:  result_next = a | b;
            OP_XOR: result_next = a ^ b;
            OP_NOT: result_next = ~a;
            OP_SHL: begin
                result_next = {a[WIDTH-2:0], 1'b0};
                carry_next  = a[MSB];
            end
            OP_SHR: begin
                result_next = {1'b0, a[WIDTH-1:1]};
                carry_next  = a[0];
            end
            default: begin
                result_next = '0;
                carry_next  = 1'b0;
                ovf_next    = 1'b0;
            end
        endcase
    end

    // Result and flags only move on an accepted input and otherwise hold.
    // out_valid simply follows in_valid, which gives one pulse per input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            c         <= 1'b0;
            z         <= 1'b0;
            n         <= 1'b0;
            v         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= result_next;
                c <= carry_next;
                z <= (result_next == '0);
                n <= result_next[MSB];
                v <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (WIDTH=4)
//
// Expected results are pushed to a scoreboard queue as each input is driven.
// A monitor pops them when out_valid is expected and otherwise checks that
// the result and flags hold their previous value.
// ---------------------------------------------------------------------------
module tb_alu;

    typedef struct {
        logic [2:0] s;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic [3:0] y;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic       out_valid;

    int   total;
    int   bad;
    vec_t sb[$];
    vec_t last;
    vec_t tbl[16];

    alu #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .s         (s),
        .y         (y),
        .c         (c),
        .z         (z),
        .n         (n),
        .v         (v),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] ts, input logic [3:0] ta, input logic [3:0] tb,
                                input logic [3:0] ty, input logic tc, input logic tz,
                                input logic tn, input logic tv);
        vec_t r;
        r.s = ts; r.a = ta; r.b = tb; r.y = ty;
        r.c = tc; r.z = tz; r.n = tn; r.v = tv;
        return r;
    endfunction

    function automatic int sgn(input logic [3:0] x);
        int ix;
        ix = int'(x);
        return (ix >= 8) ? ix - 16 : ix;
    endfunction

    // Integer-arithmetic reference used for the random vectors.
    function automatic vec_t modelAlu(input logic [2:0] ts, input logic [3:0] ta, input logic [3:0] tb);
        vec_t r;
        int   ia;
        int   ib;
        int   iy;
        int   sv;
        ia = int'(ta);
        ib = int'(tb);
        iy = 0;
        r.s = ts; r.a = ta; r.b = tb;
        r.c = 1'b0; r.v = 1'b0;
        case (ts)
            3'd0: begin
                iy  = (ia + ib) % 16;
                r.c = (ia + ib) > 15;
                sv  = sgn(ta) + sgn(tb);
                r.v = (sv > 7) || (sv < -8);
            end
            3'd1: begin
                iy  = (ia - ib + 16) % 16;
                r.c = ia < ib;
                sv  = sgn(ta) - sgn(tb);
                r.v = (sv > 7) || (sv < -8);
            end
            3'd2: iy = int'(ta & tb);
            3'd3: iy = int'(ta | tb);
            3'd4: iy = int'(ta ^ tb);
            3'd5: iy = 15 - ia;
            3'd6: begin
                iy  = (ia * 2) % 16;
                r.c = ia >= 8;
            end
            default: begin
                iy  = ia / 2;
                r.c = (ia % 2) == 1;
            end
        endcase
        r.y = 4'(iy);
        r.z = (iy == 0);
        r.n = (iy >= 8);
        return r;
    endfunction

    task automatic applyStimulus(input vec_t t, input bit valid);
        @(negedge clk);
        in_valid = valid;
        s        = t.s;
        a        = t.a;
        b        = t.b;
        if (valid) sb.push_back(t);
    endtask

    // Monitor: one out_valid check per cycle, then either a scoreboard
    // pop (result expected) or a hold check against the last result.
    always @(posedge clk) begin
        bit   exp_v;
        vec_t e;
        exp_v = in_valid && rst_n;
        #1;
        if (!rst_n) last = mk(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("out_valid", int'(out_valid), int'(exp_v));
        if (exp_v) begin
            if (sb.size() == 0) begin
                checkOutput("scoreboard_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("y s=%0d a=%h b=%h", e.s, e.a, e.b), int'(y), int'(e.y));
                checkOutput($sformatf("c s=%0d a=%h b=%h", e.s, e.a, e.b), int'(c), int'(e.c));
                checkOutput($sformatf("z s=%0d a=%h b=%h", e.s, e.a, e.b), int'(z), int'(e.z));
                checkOutput($sformatf("n s=%0d a=%h b=%h", e.s, e.a, e.b), int'(n), int'(e.n));
                checkOutput($sformatf("v s=%0d a=%h b=%h", e.s, e.a, e.b), int'(v), int'(e.v));
                last = e;
            end
        end else begin
            checkOutput("hold_y", int'(y), int'(last.y));
            checkOutput("hold_c", int'(c), int'(last.c));
            checkOutput("hold_z", int'(z), int'(last.z));
            checkOutput("hold_n", int'(n), int'(last.n));
            checkOutput("hold_v", int'(v), int'(last.v));
        end
    end

    initial begin
        vec_t idle;
        vec_t t;
        total = 0;
        bad   = 0;
        idle  = mk(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        last  = idle;

        //                s     a        b        y        c     z     n     v
        tbl[0]  = mk(3'd0, 4'b1001, 4'b0011, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[1]  = mk(3'd1, 4'b1001, 4'b1011, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[2]  = mk(3'd2, 4'b1001, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(3'd3, 4'b1101, 4'b1011, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mk(3'd4, 4'b1011, 4'b0111, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[5]  = mk(3'd5, 4'b1010, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(3'd6, 4'b1110, 4'b0000, 4'b1100, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[7]  = mk(3'd7, 4'b0101, 4'b1010, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(3'd0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(3'd1, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(3'd1, 4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(3'd0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[12] = mk(3'd6, 4'b0111, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[13] = mk(3'd7, 4'b1000, 4'b0101, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(3'd5, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[15] = mk(3'd1, 4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);

        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        s        = '0;

        // Reset assert: outputs clear without any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_y", int'(y), 0);
        checkOutput("reset_c", int'(c), 0);
        checkOutput("reset_z", int'(z), 0);
        checkOutput("reset_n", int'(n), 0);
        checkOutput("reset_v", int'(v), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(idle, 1'b0);

        $display("[TB] directed vectors");
        for (int i = 0; i < 16; i++) applyStimulus(tbl[i], 1'b1);

        // Idle cycles with junk on the operand bus: result must hold.
        for (int i = 0; i < 3; i++) begin
            t = modelAlu(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            applyStimulus(t, 1'b0);
        end

        $display("[TB] random vectors");
        for (int i = 0; i < 80; i++) begin
            t = modelAlu(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            applyStimulus(t, $urandom_range(0, 3) != 0);
        end

        // Reset in the middle of a pending operation.
        $display("[TB] mid-stream reset");
        applyStimulus(mk(3'd0, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        s        = 3'd5;
        a        = 4'b0000;
        b        = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_y", int'(y), 0);
        checkOutput("midreset_c", int'(c), 0);
        checkOutput("midreset_z", int'(z), 0);
        checkOutput("midreset_n", int'(n), 0);
        checkOutput("midreset_v", int'(v), 0);
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) applyStimulus(idle, 1'b0);
        applyStimulus(tbl[9], 1'b1);
        repeat (2) applyStimulus(idle, 1'b0);
        @(negedge clk);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
